// File: rtl/ldtu_sample_packer.sv
// ldtu_sample_packer: packs baseline (5x6b) and signal (2x13b) samples into 32-bit words, buffered in a FWFT FIFO.
// Optional macro LDTU_PACK_IDLE_EN: an empty FIFO presents IDLE_PATTERN with out_valid held high.
module ldtu_sample_packer #(
  parameter int          OUT_FIFO_DEPTH = 4,
  parameter logic [31:0] IDLE_PATTERN   = 32'hEAAAAAAA
) (
  input  logic                              CLK,
  input  logic                              rst,
  input  logic [12:0]                       DATA_to_enc,
  input  logic                              baseline_flag,
  input  logic                              in_valid,
  input  logic                              flush,
  output logic [31:0]                       DATA_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(OUT_FIFO_DEPTH):0]   fifo_level,
  output logic                              overflow
);
  localparam int AW = $clog2(OUT_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(OUT_FIFO_DEPTH);
  localparam logic [LW-1:0] LEVEL_ZERO = {LW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
`ifdef LDTU_PACK_IDLE_EN
  localparam logic IDLE_EN = 1'b1;
`else
  localparam logic IDLE_EN = 1'b0;
`endif
  localparam logic [31:0] EMPTY_WORD = IDLE_EN ? IDLE_PATTERN : 32'h0000_0000;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BASE = 2'd1, ST_SIG = 2'd2} state_t;

  state_t        state_r;
  logic [2:0]    count_r;
  logic [23:0]   base_buf_r;
  logic [12:0]   sig_buf_r;
  logic          push_s;
  logic [31:0]   word_s;
  logic [31:0]   base_part_s;
  logic [31:0]   sig_part_s;
  logic [23:0]   buf_in_s;
  logic [4:0]    shamt_s;

  logic [31:0]   mem_r [OUT_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [LW-1:0] level_r;
  logic          overflow_r;
  logic [31:0]   data_out_r;
  logic          out_valid_r;
  logic          pop_s;
  logic          wr_s;
  logic          drop_s;
  logic [LW-1:0] level_nx_s;
  logic [LW-1:0] after_pop_s;
  logic [AW-1:0] rd_nx_s;
  logic [31:0]   head_nx_s;

  // Word assembly: decides whether this edge completes a word and what it holds
  always_comb begin
    push_s      = 1'b0;
    word_s      = 32'h0000_0000;
    base_part_s = {3'b110, count_r, 2'b00, base_buf_r};
    sig_part_s  = {6'b001011, 13'h0000, sig_buf_r};
    buf_in_s    = {18'h00000, DATA_to_enc[5:0]};
    shamt_s     = {count_r, 2'b00} + {1'b0, count_r, 1'b0};
    case (state_r)
      ST_IDLE: begin
        push_s = 1'b0;
        word_s = 32'h0000_0000;
      end
      ST_BASE: begin
        if (in_valid) begin
          if (baseline_flag) begin
            push_s = (count_r == 3'd4);
            word_s = {2'b01, DATA_to_enc[5:0], base_buf_r};
          end else begin
            push_s = 1'b1;
            word_s = base_part_s;
          end
        end else begin
          push_s = flush;
          word_s = base_part_s;
        end
      end
      ST_SIG: begin
        if (in_valid) begin
          push_s = 1'b1;
          word_s = baseline_flag ? sig_part_s : {6'b001010, DATA_to_enc, sig_buf_r};
        end else begin
          push_s = flush;
          word_s = sig_part_s;
        end
      end
      default: begin
        push_s = 1'b0;
        word_s = 32'h0000_0000;
      end
    endcase
  end

  // Packer FSM: tracks sample type and count; base_buf_r is kept zero above the held samples
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      count_r    <= 3'd0;
      base_buf_r <= 24'h000000;
      sig_buf_r  <= 13'h0000;
    end else if (in_valid && baseline_flag) begin
      case (state_r)
        ST_BASE: begin
          if (count_r == 3'd4) begin
            state_r    <= ST_IDLE;
            count_r    <= 3'd0;
            base_buf_r <= 24'h000000;
          end else begin
            count_r    <= count_r + 3'd1;
            base_buf_r <= base_buf_r | (buf_in_s << shamt_s);
          end
        end
        default: begin
          state_r    <= ST_BASE;
          count_r    <= 3'd1;
          base_buf_r <= buf_in_s;
        end
      endcase
    end else if (in_valid) begin
      case (state_r)
        ST_SIG: begin
          state_r <= ST_IDLE;
          count_r <= 3'd0;
        end
        default: begin
          state_r    <= ST_SIG;
          count_r    <= 3'd0;
          base_buf_r <= 24'h000000;
          sig_buf_r  <= DATA_to_enc;
        end
      endcase
    end else if (flush) begin
      state_r    <= ST_IDLE;
      count_r    <= 3'd0;
      base_buf_r <= 24'h000000;
    end else begin
      state_r <= state_r;
    end
  end

  // FIFO control: a push while full is accepted only alongside a pop; the next head is precomputed
  always_comb begin
    pop_s       = out_ready && (level_r != LEVEL_ZERO);
    wr_s        = push_s && ((level_r != FULL_LEVEL) || pop_s);
    drop_s      = push_s && (level_r == FULL_LEVEL) && !pop_s;
    after_pop_s = level_r - {{(LW-1){1'b0}}, pop_s};
    level_nx_s  = after_pop_s + {{(LW-1){1'b0}}, wr_s};
    rd_nx_s     = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    if (level_nx_s == LEVEL_ZERO) begin
      head_nx_s = EMPTY_WORD;
    end else if (after_pop_s == LEVEL_ZERO) begin
      head_nx_s = word_s;
    end else begin
      head_nx_s = mem_r[rd_nx_s];
    end
  end

  // FIFO storage array (contents need no reset; the pointers define validity)
  always_ff @(posedge CLK) begin
    if (!rst && wr_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, occupancy, sticky overflow and registered output head
  always_ff @(posedge CLK) begin
    if (rst) begin
      rd_ptr_r    <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      level_r     <= LEVEL_ZERO;
      overflow_r  <= 1'b0;
      data_out_r  <= 32'h0000_0000;
      out_valid_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r    <= rd_nx_s;
      level_r     <= level_nx_s;
      overflow_r  <= overflow_r | drop_s;
      data_out_r  <= head_nx_s;
      out_valid_r <= (level_nx_s != LEVEL_ZERO) | IDLE_EN;
    end
  end

  assign DATA_out   = data_out_r;
  assign out_valid  = out_valid_r;
  assign fifo_level = level_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_ldtu_sample_packer.sv
// Directed self-checking bench for ldtu_sample_packer with hand-computed packed words.
module tb_ldtu_sample_packer;
  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] DATA_to_enc = 13'h0000;
  logic        baseline_flag = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] DATA_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  fifo_level;
  logic        overflow;

`ifdef LDTU_PACK_IDLE_EN
  localparam logic [31:0] EMPTY_DATA  = 32'hEAAAAAAA;
  localparam logic        EMPTY_VALID = 1'b1;
`else
  localparam logic [31:0] EMPTY_DATA  = 32'h0000_0000;
  localparam logic        EMPTY_VALID = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ldtu_sample_packer #(.OUT_FIFO_DEPTH(4), .IDLE_PATTERN(32'hEAAAAAAA)) dut (
    .CLK(CLK), .rst(rst), .DATA_to_enc(DATA_to_enc), .baseline_flag(baseline_flag),
    .in_valid(in_valid), .flush(flush), .DATA_out(DATA_out), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [12:0] d, input logic bl);
    DATA_to_enc   = d;
    baseline_flag = bl;
    in_valid      = 1'b1;
    tick();
    in_valid      = 1'b0;
    DATA_to_enc   = 13'h0000;
  endtask

  function automatic logic [31:0] sig_word(input logic [12:0] s0, input logic [12:0] s1);
    return {6'b001010, s1, s0};
  endfunction

  logic [31:0] exp_words [6];
  int          drain_order [4] = '{1, 2, 3, 5};

  initial begin
    // reset state
    tick();
    tick();
    check_eq("rst_data", DATA_out, 32'h0);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_level", {29'd0, fifo_level}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("empty_data", DATA_out, EMPTY_DATA);
    check_eq("empty_valid", {31'd0, out_valid}, {31'd0, EMPTY_VALID});

    // five baselines -> one full baseline word
    for (int i = 1; i <= 4; i++) send(13'(i), 1'b1);
    check_eq("base4_level", {29'd0, fifo_level}, 32'd0);
    send(13'h0005, 1'b1);
    check_eq("base_full", DATA_out, 32'h45103081);
    check_eq("base_full_valid", {31'd0, out_valid}, 32'd1);
    check_eq("base_full_level", {29'd0, fifo_level}, 32'd1);
    tick();
    check_eq("base_pop_level", {29'd0, fifo_level}, 32'd0);
    check_eq("base_pop_data", DATA_out, EMPTY_DATA);

    // full signal word
    send(13'h1ABC, 1'b0);
    send(13'h0123, 1'b0);
    check_eq("sig_full", DATA_out, 32'h28247ABC);
    tick();

    // partial baseline on type change, then full signal with same-edge pop
    send(13'h003F, 1'b1);
    send(13'h0001, 1'b1);
    send(13'h0800, 1'b0);
    check_eq("base_part2", DATA_out, 32'hC800007F);
    send(13'h0001, 1'b0);
    check_eq("sig_after_part", DATA_out, 32'h28002800);
    check_eq("sig_after_part_lvl", {29'd0, fifo_level}, 32'd1);

    // partial signal, then flush of four held baselines
    send(13'h1000, 1'b0);
    send(13'h0000, 1'b1);
    check_eq("sig_part", DATA_out, 32'h2C001000);
    for (int i = 0; i < 3; i++) send(13'h0000, 1'b1);
    flush = 1'b1;
    tick();
    check_eq("flush_base4", DATA_out, {3'b110, 3'd4, 26'd0});
    check_eq("flush_level", {29'd0, fifo_level}, 32'd1);
    tick();
    flush = 1'b0;
    check_eq("flush_idle_level", {29'd0, fifo_level}, 32'd0);

    // overflow: five pairs with no pops, then a push+pop while full
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) exp_words[k] = sig_word(13'h0100 + 13'(k), 13'h1200 + 13'(k));
    for (int k = 0; k < 4; k++) begin
      send(13'h0100 + 13'(k), 1'b0);
      send(13'h1200 + 13'(k), 1'b0);
    end
    check_eq("fill_level", {29'd0, fifo_level}, 32'd4);
    check_eq("fill_ovf", {31'd0, overflow}, 32'd0);
    send(13'h0104, 1'b0);
    send(13'h1204, 1'b0);
    check_eq("drop_level", {29'd0, fifo_level}, 32'd4);
    check_eq("drop_ovf", {31'd0, overflow}, 32'd1);
    check_eq("drop_head", DATA_out, exp_words[0]);
    send(13'h0105, 1'b0);
    out_ready = 1'b1;
    send(13'h1205, 1'b0);
    check_eq("fullpp_level", {29'd0, fifo_level}, 32'd4);
    for (int j = 0; j < 4; j++) begin
      check_eq($sformatf("drain%0d", j), DATA_out, exp_words[drain_order[j]]);
      tick();
    end
    check_eq("drained_level", {29'd0, fifo_level}, 32'd0);
    check_eq("drained_valid", {31'd0, out_valid}, {31'd0, EMPTY_VALID});
    check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
    tick();
    check_eq("pop_empty_level", {29'd0, fifo_level}, 32'd0);

    // reset mid-word discards held samples and clears overflow
    for (int i = 0; i < 3; i++) send(13'h0007, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_ovf", {31'd0, overflow}, 32'd0);
    check_eq("rst2_level", {29'd0, fifo_level}, 32'd0);
    send(13'h0001, 1'b0);
    check_eq("rst2_nothing", {29'd0, fifo_level}, 32'd0);
    send(13'h0002, 1'b0);
    check_eq("rst2_word", DATA_out, 32'h28004001);
    check_eq("rst2_word_lvl", {29'd0, fifo_level}, 32'd1);
    tick();
    check_eq("rst2_final_lvl", {29'd0, fifo_level}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ldtu_sample_packer.md
Name: ldtu_sample_packer

Overview:
- Consumes the 13-bit sample stream from the input-FIFO/gain-selection stage: bit 12 is the gain bit, bits 11:0 are data, plus a per-sample baseline flag.
- Packs consecutive baseline samples (6 LSBs each) five per 32-bit word and signal samples (13 bits) two per word.
- When the sample type changes, or on a flush request, the partially filled word is closed early with a header that identifies it as partial.
- Completed words go into a small output FIFO with a valid/ready handshake toward the serializer stage.

Parameters:
- OUT_FIFO_DEPTH, 4, output FIFO depth in words; power of two, minimum 2.
- IDLE_PATTERN, 32'hEAAAAAAA, word driven while the FIFO is empty (LDTU_PACK_IDLE_EN only).

Ports:
- CLK  input  1  LiTe-DTU clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- DATA_to_enc  input  13  sample from the upstream stage; [12] gain bit, [11:0] data.
- baseline_flag  input  1  1 = baseline sample, 0 = signal sample.
- in_valid  input  1  the sample is consumed on every edge where in_valid=1.
- flush  input  1  close the partial word; honoured only when in_valid=0.
- DATA_out  output  32  head word of the output FIFO.
- out_valid  output  1  DATA_out holds a word.
- out_ready  input  1  the downstream stage pops the word on an edge with out_valid & out_ready.
- fifo_level  output  clog2(OUT_FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when a word is dropped because the FIFO is full.

Behaviour:
- Reset: rst=1 at an edge clears all state.
  - Packer goes to IDLE with count 0; FIFO is emptied.
  - fifo_level=0, overflow=0, out_valid=0, DATA_out=0.
  - Reset applied mid-word discards the partial word; nothing is emitted.
- Packer states: IDLE, BASE(c) with c in 1..4 baseline samples held, SIG with 1 signal sample held.
- Word formats (bit 31 is MSB; sample 0 is the oldest and sits in the LSBs):
  - Full baseline: [31:30]=2'b01, B4..B0 at [29:24],[23:18],[17:12],[11:6],[5:0]. Each Bn = DATA_to_enc[5:0]; the gain bit is dropped.
  - Full signal: [31:26]=6'b001010, S1 at [25:13], S0 at [12:0].
  - Partial baseline: [31:26]={3'b110, c[2:0]}, [25:24]=0, c samples packed from bit 0 upward, unused bits 0.
  - Partial signal: [31:26]=6'b001011, [25:13]=0, S0 at [12:0].
- Transitions on an edge with in_valid=1:
  - IDLE: baseline -> BASE(1); signal -> SIG.
  - BASE(c), baseline: c<4 -> BASE(c+1); c=4 -> emit full baseline word, go to IDLE.
  - BASE(c), signal: emit partial baseline word (count c), go to SIG holding the new sample.
  - SIG, signal: emit full signal word, go to IDLE.
  - SIG, baseline: emit partial signal word, go to BASE(1) holding the new sample.
- Transitions on an edge with in_valid=0:
  - flush=1 in BASE(c) or SIG: emit the partial word, go to IDLE.
  - flush=1 in IDLE: no action.
  - flush=0: state holds.
- At most one word is emitted per cycle.
- Emitted words are written into the FIFO on the same edge the completing sample (or flush) is taken.
  - Latency: the word appears on DATA_out with out_valid=1 directly after that edge when the FIFO was empty (first-word fall-through).
- FIFO:
  - Circular buffer; pointers wrap modulo OUT_FIFO_DEPTH.
  - Pop and push on the same edge are both performed, including when the FIFO is full.
  - Push while full with no pop: the word is dropped, FIFO contents are unchanged, overflow is set to 1 and held until rst.
  - Pop while empty: ignored.

Optional Feature:
- Macro LDTU_PACK_IDLE_EN.
- Defined:
  - out_valid is held at 1 after reset is released.
  - When the FIFO is empty, DATA_out=IDLE_PATTERN; a handshake on an idle word does not change FIFO state.
  - Idle words never enter the FIFO.
- Not defined: out_valid = FIFO non-empty; DATA_out=0 when empty.

Test Plan:
- Five baseline samples 0x001,0x002,0x003,0x004,0x005, out_ready=1 -> one word 0x45103081, appearing the cycle after the 5th sample; fifo_level returns to 0 after the pop.
- Signal samples 0x1ABC then 0x0123 -> one word 0x28247ABC.
- Baselines 0x03F,0x001 then signal 0x0800 -> partial word 0xC800007F; state SIG; a following signal 0x0001 gives 0x28002800.
- Signal 0x1000 then baseline 0x000 -> 0x2C001000. Then three more baselines and flush=1 with in_valid=0 -> 0xD4000000 (count 4, all zero).
- out_ready=0 with signal pairs streamed -> four words stored, the 5th is dropped, overflow=1 and stays 1 after out_ready=1 drains the FIFO; only rst clears it.
- Three baselines, then rst=1 for one cycle, then two signals 0x0001,0x0002 -> only 0x28004001 is emitted. With LDTU_PACK_IDLE_EN, an empty FIFO shows 0xEAAAAAAA with out_valid=1.
